// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the core store bus.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mmio_hit,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

`ifdef MMIO_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, sh_n;
  logic          tx_n;
  logic          busy_n;
  logic          baud_end;
`ifdef MMIO_UART_PARITY_EN
  logic          par_q, par_n;
`endif

  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          overflow;

  logic          hit_data, hit_stat;
  logic          fifo_full, fifo_empty;
  logic          push_req, push_ok, pop;
  logic          ovf_set, ovf_clr;
  logic [31:0]   status, cnt32;
  logic          unused_wdata;

  assign hit_data   = (mem_addr == BASE_ADDR);
  assign hit_stat   = (mem_addr == BASE_ADDR + 32'd4);
  assign mmio_hit   = hit_data | hit_stat;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);

  // A push into a full FIFO still lands when the serialiser pops on the same edge.
  assign push_req   = mem_we & hit_data;
  assign push_ok    = push_req & (~fifo_full | pop);
  assign ovf_set    = push_req & fifo_full & ~pop;
  assign ovf_clr    = mem_we & hit_stat & mem_wdata[3];
  assign count_n    = count + CW'(push_ok) - CW'(pop);

  assign unused_wdata = ^mem_wdata[31:8];

  always_comb begin
    cnt32       = 32'(count);
    status      = '0;
    status[0]   = tx_busy;
    status[1]   = fifo_full;
    status[2]   = fifo_empty;
    status[3]   = overflow;
    status[7:4] = (cnt32 > 32'd15) ? 4'hF : cnt32[3:0];
`ifdef MMIO_UART_PARITY_EN
    status[8]   = 1'b1;
`endif
  end

  assign mem_rdata = hit_stat ? status : '0;

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign baud_end = (baud == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    sh_n    = shreg;
    tx_n    = tx;
    pop     = 1'b0;
`ifdef MMIO_UART_PARITY_EN
    par_n   = par_q;
`endif
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = fifo[rd_ptr];
          state_n = S_START;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = 1'b0;
`ifdef MMIO_UART_PARITY_EN
          par_n   = ^fifo[rd_ptr];
`endif
        end
      end
      S_START: begin
        if (baud_end) begin
          state_n = S_DATA;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_n = S_PARITY;
            tx_n    = par_q;
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            // Shift so the next bit is always at [0]; drive it one edge early.
            bit_n = bit_idx + 1'b1;
            sh_n  = {1'b0, shreg[7:1]};
            tx_n  = shreg[1];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
`ifdef MMIO_UART_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          state_n = S_STOP;
          baud_n  = '0;
          tx_n    = 1'b1;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_n = '0;
          bit_n  = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_n    = fifo[rd_ptr];
            state_n = S_START;
            tx_n    = 1'b0;
`ifdef MMIO_UART_PARITY_EN
            par_n   = ^fifo[rd_ptr];
`endif
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        bit_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
    busy_n = (state_n != S_IDLE) || (count_n != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
      tx      <= tx_n;
      tx_busy <= busy_n;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a line monitor decodes 8N1 frames and checks
// them against a queue of bytes expected from the stores driven.
module tb_mmio_uart_tx;

  localparam int CPB = 4;
  localparam logic [31:0] BASE = 32'h0000_0400;

  logic        clk, reset, mem_we, mmio_hit, tx, tx_busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frames_started = 0;
  int frames_done = 0;
  int last_start_cyc = 0;
  logic [9:0] last_bits = '0;
  logic [7:0] exp_q[$];

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mmio_hit(mmio_hit), .mem_rdata(mem_rdata),
    .tx(tx), .tx_busy(tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Line monitor: centre-samples each bit; frames cut by reset are discarded.
  initial begin : monitor
    logic [9:0] bits;
    logic [7:0] want;
    bit aborted;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        frames_started++;
        last_start_cyc = cyc;
        aborted = 1'b0;
        bits = '0;
        for (int k = 0; k < 10; k++) begin
          repeat ((k == 0) ? 2 : CPB) begin
            @(negedge clk);
            if (reset !== 1'b1) aborted = 1'b1;
          end
          bits[k] = tx;
        end
        if (!aborted) begin
          frames_done++;
          last_bits = bits;
          chk("frame_start_bit", 32'(bits[0]), 32'd0);
          chk("frame_stop_bit", 32'(bits[9]), 32'd1);
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            want = exp_q.pop_front();
            chk("frame_byte", 32'(bits[8:1]), 32'(want));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    tick();
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
  endtask

  task automatic read_status(output logic [31:0] v);
    mem_we = 1'b0;
    mem_addr = BASE + 32'd4;
    #1;
    v = mem_rdata;
    mem_addr = '0;
  endtask

  task automatic wait_started(input int n, input int budget);
    int i = 0;
    while (frames_started < n && i < budget) begin tick(); i++; end
    chk("wait_started", frames_started, n);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int i = 0;
    while (frames_done < n && i < budget) begin tick(); i++; end
    chk("wait_frames", frames_done, n);
  endtask

  task automatic wait_cyc(input int target, input int budget);
    int i = 0;
    while (cyc < target && i < budget) begin tick(); i++; end
    chk("wait_cyc", cyc, target);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (tx_busy !== 1'b0 && i < budget) begin tick(); i++; end
    chk("wait_idle", 32'(tx_busy), 32'd0);
  endtask

  initial begin : stim
    logic [31:0] st;
    int s1, s2, s3, p, fs, fd, i;

    reset = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    #2 reset = 1'b1;
    tick();
    read_status(st);
    chk("rst_status", st, 32'h4);

    // single byte
    exp_q.push_back(8'hA5);
    store(BASE, 32'h0000_00A5);
    chk("a5_tx_before_pop", 32'(tx), 32'd1);
    chk("a5_busy_after_push", 32'(tx_busy), 32'd1);
    tick();
    chk("a5_tx_fall", 32'(tx), 32'd0);
    i = 0;
    while (i < 100) begin
      tick();
      i++;
      if (tx_busy === 1'b0) break;
    end
    chk("a5_busy_len", i, 40);
    wait_frames(1, 50);
    chk("a5_bits", 32'(last_bits), 32'(10'b1101001010));

    // back-to-back
    fs = frames_started; fd = frames_done;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    store(BASE, 32'h41); store(BASE, 32'h42); store(BASE, 32'h43);
    read_status(st);
    chk("b2b_status_f1", st, 32'h21);
    wait_started(fs + 1, 10);
    s1 = last_start_cyc;
    wait_started(fs + 2, 60);
    s2 = last_start_cyc;
    read_status(st);
    chk("b2b_status_f2", st, 32'h11);
    wait_started(fs + 3, 60);
    s3 = last_start_cyc;
    read_status(st);
    chk("b2b_status_f3", st, 32'h05);
    chk("b2b_gap12", s2 - s1, 40);
    chk("b2b_gap23", s3 - s2, 40);
    wait_frames(fd + 3, 60);
    wait_idle(20);
    read_status(st);
    chk("b2b_status_end", st, 32'h4);

    // overflow: 10 stores, 9 survive
    fd = frames_done;
    for (int b = 0; b < 10; b++) begin
      if (b < 9) exp_q.push_back(8'(8'h10 + b));
      store(BASE, 32'(8'h10 + b));
    end
    read_status(st);
    chk("ovf_status", st, 32'h8B);
    store(BASE + 32'd4, 32'h8);
    read_status(st);
    chk("ovf_cleared", st, 32'h83);

    // push on the final stop-bit edge while full
    p = last_start_cyc;
    wait_cyc(p + 39, 60);
    exp_q.push_back(8'h77);
    store(BASE, 32'h77);
    read_status(st);
    chk("full_pushpop_status", st, 32'h83);
    chk("full_pushpop_restart", 32'(tx), 32'd0);
    wait_frames(fd + 10, 700);
    chk("ovf_sb_drained", exp_q.size(), 0);
    wait_idle(20);
    read_status(st);
    chk("ovf_status_end", st, 32'h4);

    // reset mid-frame during data bit 3 of 0xF0
    fs = frames_started;
    exp_q.push_back(8'hF0);
    store(BASE, 32'hF0);
    wait_started(fs + 1, 10);
    p = last_start_cyc;
    wait_cyc(p + 17, 40);
    chk("midrst_tx_before", 32'(tx), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_tx_async", 32'(tx), 32'd1);
    chk("midrst_busy_async", 32'(tx_busy), 32'd0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b1;
    exp_q.delete();
    fs = frames_started;
    tick();
    read_status(st);
    chk("midrst_status", st, 32'h4);
    repeat (60) tick();
    chk("midrst_no_residual", frames_started, fs);
    chk("midrst_tx_idle", 32'(tx), 32'd1);

    // address decode
    mem_we = 1'b1; mem_wdata = 32'h55;
    mem_addr = 32'h3FC; #1;
    chk("dec_hit_3fc", 32'(mmio_hit), 32'd0);
    tick();
    mem_addr = 32'h408; #1;
    chk("dec_hit_408", 32'(mmio_hit), 32'd0);
    tick();
    mem_addr = 32'h401; #1;
    chk("dec_hit_401", 32'(mmio_hit), 32'd0);
    tick();
    mem_addr = 32'h405; mem_wdata = 32'h8; #1;
    chk("dec_hit_405", 32'(mmio_hit), 32'd0);
    tick();
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (10) tick();
    chk("dec_tx_idle", 32'(tx), 32'd1);
    chk("dec_busy", 32'(tx_busy), 32'd0);
    chk("dec_no_frame", frames_started, fs);
    mem_addr = BASE + 32'd4; #1;
    chk("dec_status_rd", mem_rdata, 32'h4);
    chk("dec_status_hit", 32'(mmio_hit), 32'd1);
    mem_addr = BASE; #1;
    chk("dec_data_rd", mem_rdata, 32'h0);
    chk("dec_data_hit", 32'(mmio_hit), 32'd1);
    mem_addr = 32'h3FC; #1;
    chk("dec_miss_rd", mem_rdata, 32'h0);
    mem_addr = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data-memory store bus, downstream of the single-cycle RISC-V core.
- Lets programs stream bytes off-chip for bring-up and regression signatures.
- Store hits at the block's address window push bytes into a small TX FIFO.
- A baud-timed FSM serialises the bytes as 8N1 frames on `tx`.
- A status register is readable combinationally, matching the core's single-cycle load path.

Parameters:
- BASE_ADDR, 32'h0000_0400, word-aligned base of the 8-byte register window.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 2.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, ≥ 2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- mem_we  input  1  core store enable (single-cycle, one store per clock).
- mem_addr  input  32  core data address.
- mem_wdata  input  32  core store data.
- mmio_hit  output  1  combinational; 1 when mem_addr is BASE_ADDR or BASE_ADDR+4. Top uses it to mux mem_rdata and to suppress the data-RAM write.
- mem_rdata  output  32  combinational read data (see register map).
- tx  output  1  serial line; idles high.
- tx_busy  output  1  registered; 1 while the FIFO is non-empty or a frame is in flight.

Behaviour:
- Register map:
  - DATA @BASE+0: write pushes mem_wdata[7:0]; reads return 0.
  - STATUS @BASE+4, read:
    - [0] tx_busy
    - [1] fifo_full
    - [2] fifo_empty
    - [3] overflow (sticky)
    - [7:4] FIFO count (saturates display at 15)
    - [31:8] 0
  - STATUS write: wdata[3]=1 clears overflow; other bits are ignored.
- mem_rdata is 0 when mmio_hit=0.
- Reset (asserted low, async), all state cleared immediately:
  - tx=1, tx_busy=0, FSM=IDLE.
  - FIFO emptied: pointers=0, count=0.
  - overflow=0, baud counter=0, bit index=0.
- FIFO: circular buffer with wrap-around read/write pointers and a separate count, so full and empty are distinguishable.
  - Push when full: byte dropped, overflow set, FIFO unchanged.
  - Push and pop on the same edge: both take effect and count is unchanged, including when full.
- Serialiser FSM: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty at an edge: pop the head into the shift register, go to START, register tx=0.
    - Latency: a store captured at edge E0 into an empty FIFO with the FSM idle makes tx fall at E1.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA and drive bit0.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Bit index counts 0..7; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On its final cycle:
    - FIFO non-empty: pop and go directly to START (no idle gap; frames are back-to-back).
    - FIFO empty: go to IDLE.
- Timing:
  - Baud counter counts 0..CLKS_PER_BIT-1, reloads at each bit boundary, and is zeroed on entering START.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - tx is driven from a flop (glitch-free).
- tx_busy is registered: 1 when FSM≠IDLE or count≠0 after the edge.
- Bus rules:
  - Writes to BASE+1..3 or BASE+5..7 are ignored; mmio_hit covers exact word addresses only.
  - Any address outside the window has no effect.
- Reset mid-frame aborts the frame: tx=1 asynchronously and the partial byte is lost.

Optional Feature:
- Macro: MMIO_UART_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP; it transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
  - STATUS[8]=1 reports that parity is present.
- Not defined: no PARITY state, 8N1 frames of 10*CLKS_PER_BIT, STATUS[8]=0.

Test Plan:
- Single byte: CLKS_PER_BIT=4, reset released, store 32'h0000_00A5 to 32'h400 → tx falls the next edge. Sampled bit centres read 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop). tx_busy drops 40 cycles after the fall.
- Back-to-back: store 0x41, 0x42, 0x43 on consecutive cycles → three contiguous 40-cycle frames, no idle gap. Status count reads 3→2→1→0 across the pops, and fifo_empty=1 at the end.
- Overflow: FIFO_DEPTH=8. Store 10 bytes in consecutive cycles while the first frame is in flight → 9 bytes transmitted (1 in flight + 8 queued), STATUS[3]=1. Store wdata=32'h8 to 32'h404 → STATUS[3]=0.
- Simultaneous push/pop at full: time a store to the final STOP cycle with count=8 → byte accepted, count stays 8, overflow stays 0.
- Reset mid-frame: assert reset low during DATA bit 3 → tx=1 in the same cycle (async). STATUS reads 32'h4 after release, and no residual frame follows.
- Address decode: store to 32'h3FC and 32'h408 → mmio_hit=0, tx stays 1. Load 32'h404 with an empty FIFO → mem_rdata=32'h4, mmio_hit=1.
